fetch_unit: RTL and testbench

//  Instruction-fetch stage. Closes the redirect loop from the execute stage:

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem, registers IF/ID and
// redirects on a taken leap from execute, ignoring leap for a shadow window.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h5400_0000,
    parameter int          SHADOW    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        leap,
    input  logic [31:0] leapAddr,
    output logic [31:0] instAddr,
    input  logic [31:0] instIn,
    output logic [31:0] instr_id,
    output logic [31:0] nextPC_id,
    output logic        valid_id,
    output logic        flush_ex,
    output logic        align_err
);

    // state       | meaning
    // RUN         | normal fetch, leap is honoured
    // SHADOW_WAIT | post-redirect window, leap ignored for SHADOW advancing cycles
    typedef enum logic {
        RUN,
        SHADOW_WAIT
    } state_t;

    localparam logic [1:0] SHADOW_INIT = 2'(SHADOW);

    state_t      state;
    logic [1:0]  shadow_cnt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        take;

    assign take     = leap && (state == RUN);
    assign flush_ex = take;
    assign instAddr = pc;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            instr_id   <= NOP_INSTR;
            nextPC_id  <= 32'h0;
            valid_id   <= 1'b0;
            align_err  <= 1'b0;
            state      <= RUN;
            shadow_cnt <= 2'd0;
        end else if (take) begin
            // Low two address bits (bits 30:31 in MSB-first numbering) are dropped.
            pc        <= {leapAddr[31:2], 2'b00};
            instr_id  <= NOP_INSTR;
            nextPC_id <= 32'h0;
            valid_id  <= 1'b0;
            if (leapAddr[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end
            if (SHADOW > 0) begin
                state      <= SHADOW_WAIT;
                shadow_cnt <= SHADOW_INIT;
            end
        end else if (!stall) begin
            pc        <= pc_plus4;
            instr_id  <= instIn;
            nextPC_id <= pc_plus4;
            valid_id  <= 1'b1;
            if (state == SHADOW_WAIT) begin
                if (shadow_cnt <= 2'd1) begin
                    state      <= RUN;
                    shadow_cnt <= 2'd0;
                end else begin
                    shadow_cnt <= shadow_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h5400_0000;

    logic        clk = 1'b0;
    logic        reset, stall, leap;
    logic [31:0] leapAddr, instAddr, instIn, instr_id, nextPC_id;
    logic        valid_id, flush_ex, align_err;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        flush;
        logic        align;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .SHADOW(1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .leap(leap), .leapAddr(leapAddr),
        .instAddr(instAddr), .instIn(instIn), .instr_id(instr_id),
        .nextPC_id(nextPC_id), .valid_id(valid_id), .flush_ex(flush_ex),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Combinational imem: data is the inverted address.
    assign instIn = ~instAddr;

    task automatic chk32(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: every cycle outputs are presented mid-cycle; compare against scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk32(e.name, "instAddr",  instAddr,          e.addr);
            chk32(e.name, "instr_id",  instr_id,          e.instr);
            chk32(e.name, "nextPC_id", nextPC_id,         e.npc);
            chk32(e.name, "valid_id",  {31'b0, valid_id}, {31'b0, e.valid});
            chk32(e.name, "flush_ex",  {31'b0, flush_ex}, {31'b0, e.flush});
            chk32(e.name, "align_err", {31'b0, align_err},{31'b0, e.align});
        end
    end

    // Drive one cycle of inputs and push the outputs expected during that cycle.
    task automatic step(input string nm, input logic rst, input logic stl, input logic lp,
                        input logic [31:0] la, input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_npc, input logic e_valid, input logic e_flush,
                        input logic e_align);
        exp_t e;
        #1;
        reset = rst; stall = stl; leap = lp; leapAddr = la;
        e.name = nm; e.addr = e_addr; e.instr = e_instr; e.npc = e_npc;
        e.valid = e_valid; e.flush = e_flush; e.align = e_align;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; leap = 1'b0; leapAddr = 32'h0;
        repeat (2) @(posedge clk);
        //    name         rst  stl  lp   leapAddr       addr           instr          npc           v   fl  al
        step("reset",      0,   0,   0,   32'h0,         32'h0,         NOP,           32'h0,        0,  0,  0);
        step("adv4",       0,   0,   0,   32'h0,         32'h4,         ~32'h0,        32'h4,        1,  0,  0);
        step("adv8",       0,   0,   0,   32'h0,         32'h8,         ~32'h4,        32'h8,        1,  0,  0);
        step("advC",       0,   0,   0,   32'h0,         32'hC,         ~32'h8,        32'hC,        1,  0,  0);
        step("stall1",     0,   1,   0,   32'h0,         32'h10,        ~32'hC,        32'h10,       1,  0,  0);
        step("stall2",     0,   1,   0,   32'h0,         32'h10,        ~32'hC,        32'h10,       1,  0,  0);
        step("stall3",     0,   1,   0,   32'h0,         32'h10,        ~32'hC,        32'h10,       1,  0,  0);
        step("release",    0,   0,   0,   32'h0,         32'h10,        ~32'hC,        32'h10,       1,  0,  0);
        step("resume14",   0,   0,   0,   32'h0,         32'h14,        ~32'h10,       32'h14,       1,  0,  0);
        step("adv18",      0,   0,   0,   32'h0,         32'h18,        ~32'h14,       32'h18,       1,  0,  0);
        step("adv1C",      0,   0,   0,   32'h0,         32'h1C,        ~32'h18,       32'h1C,       1,  0,  0);
        step("leap100",    0,   0,   1,   32'h100,       32'h20,        ~32'h1C,       32'h20,       1,  1,  0);
        step("shadow_ign", 0,   0,   1,   32'h200,       32'h100,       NOP,           32'h0,        0,  0,  0);
        step("leap_stall", 0,   1,   1,   32'h40,        32'h104,       ~32'h100,      32'h104,      1,  1,  0);
        step("bubble40",   0,   0,   0,   32'h0,         32'h40,        NOP,           32'h0,        0,  0,  0);
        step("leap103",    0,   0,   1,   32'h103,       32'h44,        ~32'h40,       32'h44,       1,  1,  0);
        step("shd_stall",  0,   1,   1,   32'h300,       32'h100,       NOP,           32'h0,        0,  0,  1);
        step("shd_held",   0,   0,   1,   32'h300,       32'h100,       NOP,           32'h0,        0,  0,  1);
        step("leap_top",   0,   0,   1,   32'hFFFF_FFFC, 32'h104,       ~32'h100,      32'h104,      1,  1,  1);
        step("at_top",     0,   0,   0,   32'h0,         32'hFFFF_FFFC, NOP,           32'h0,        0,  0,  1);
        step("wrapped",    0,   0,   1,   32'h80,        32'h0,         32'h3,         32'h0,        1,  1,  1);
        step("rst_shadow", 1,   0,   1,   32'h500,       32'h80,        NOP,           32'h0,        0,  0,  1);
        step("post_rst",   0,   0,   1,   32'h8,         32'h0,         NOP,           32'h0,        0,  1,  0);
        step("leap8",      0,   0,   0,   32'h0,         32'h8,         NOP,           32'h0,        0,  0,  0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
